// File: rtl/flow_control_pkg.sv
// Shared definitions for the valid/ready register slice.
package flow_control_pkg;

  localparam int DATA_SIZE_DEFAULT = 8;

  // Encoding chosen so bit 0 means "main word valid" and bit 1 means "skid word valid".
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b11
  } fc_state_e;

endpackage

// File: rtl/flow_control_flow.sv
// Register slice with a skid entry: every output comes straight from a flop,
// yet one word per clock is sustained and nothing is lost under backpressure.
module flow_control_flow
  import flow_control_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEFAULT
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 Valid_i,
  output logic                 Ready_o,
  input  logic [DATA_SIZE-1:0] Data_i,
  output logic                 Valid_o,
  input  logic                 Ready_i,
  output logic [DATA_SIZE-1:0] Data_o
);

  fc_state_e            state_q, state_d;
  logic [DATA_SIZE-1:0] main_q, main_d;
  logic [DATA_SIZE-1:0] skid_q, skid_d;
  logic                 in_xfer;
  logic                 out_xfer;

  assign Valid_o = state_q[0];
  assign Ready_o = ~state_q[1];
  assign Data_o  = main_q;

  assign in_xfer  = Valid_i & Ready_o;
  assign out_xfer = Valid_o & Ready_i;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d = BUSY;
          main_d  = Data_i;
        end
      end
      BUSY: begin
        if (in_xfer && out_xfer) begin
          main_d = Data_i;
        end else if (in_xfer) begin
          // Consumer stalled: park the new word so Data_o stays stable.
          state_d = FULL;
          skid_d  = Data_i;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          state_d = BUSY;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

endmodule

// File: tb/tb_flow_control_flow.sv
// Directed bench for flow_control_flow: a depth-2 FIFO model checked every cycle,
// plus hand-computed literal expectations at key points of the scenario.
module tb_flow_control_flow;

  logic       CLK;
  logic       RESET;
  logic       Valid_i;
  logic       Ready_o;
  logic [7:0] Data_i;
  logic       Valid_o;
  logic       Ready_i;
  logic [7:0] Data_o;

  int checks;
  int errors;

  flow_control_flow #(.DATA_SIZE(8)) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .Valid_i(Valid_i),
    .Ready_o(Ready_o),
    .Data_i (Data_i),
    .Valid_o(Valid_o),
    .Ready_i(Ready_i),
    .Data_o (Data_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural model: an ordered queue of at most two words; Data_o shows
  // the oldest word, or the last word that left (zero after reset).
  logic [7:0] mq[$];
  logic [7:0] m_last;
  bit         m_live;

  initial begin
    m_live = 0;
    m_last = 8'h00;
  end

  always @(posedge CLK) begin
    bit do_in;
    bit do_out;
    if (RESET) begin
      mq.delete();
      m_last = 8'h00;
      m_live = 1;
    end else if (m_live) begin
      do_in  = Valid_i && (mq.size() < 2);
      do_out = (mq.size() > 0) && Ready_i;
      if (do_out) m_last = mq.pop_front();
      if (do_in) mq.push_back(Data_i);
    end
  end

  always @(negedge CLK) begin
    logic       ev;
    logic       er;
    logic [7:0] ed;
    if (m_live) begin
      ev = (mq.size() > 0);
      er = (mq.size() < 2);
      ed = (mq.size() > 0) ? mq[0] : m_last;
      checks++;
      if (Valid_o !== ev) begin
        errors++;
        $display("FAIL model_valid t=%0t got %b expected %b", $time, Valid_o, ev);
      end
      checks++;
      if (Ready_o !== er) begin
        errors++;
        $display("FAIL model_ready t=%0t got %b expected %b", $time, Ready_o, er);
      end
      checks++;
      if (Data_o !== ed) begin
        errors++;
        $display("FAIL model_data t=%0t got %h expected %h", $time, Data_o, ed);
      end
    end
  end

  task automatic step(input logic rst, input logic vi, input logic [7:0] di, input logic ri);
    RESET   = rst;
    Valid_i = vi;
    Data_i  = di;
    Ready_i = ri;
    @(posedge CLK);
    #1;
    $display("step rst=%b vi=%b di=%h ri=%b -> vo=%b ro=%b do=%h",
             rst, vi, di, ri, Valid_o, Ready_o, Data_o);
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  logic [7:0] stream_w [5];

  initial begin
    checks = 0;
    errors = 0;
    stream_w[0] = 8'h0D; stream_w[1] = 8'h8D; stream_w[2] = 8'h65;
    stream_w[3] = 8'h12; stream_w[4] = 8'h01;

    // Reset with garbage on the inputs
    step(1'b1, 1'bx, 8'hxx, 1'bx);
    step(1'b1, 1'bx, 8'hxx, 1'bx);
    chk("rst_valid", {7'd0, Valid_o}, 8'h00);
    chk("rst_ready", {7'd0, Ready_o}, 8'h01);
    chk("rst_data", Data_o, 8'h00);
    step(1'b0, 1'b0, 8'h5A, 1'b1);
    chk("idle_valid", {7'd0, Valid_o}, 8'h00);

    // Single word, held under backpressure; Data_i ignored while Valid_i=0
    step(1'b0, 1'b1, 8'h24, 1'b0);
    chk("single_valid", {7'd0, Valid_o}, 8'h01);
    chk("single_data", Data_o, 8'h24);
    chk("single_ready", {7'd0, Ready_o}, 8'h01);
    step(1'b0, 1'b0, 8'hEE, 1'b0);
    step(1'b0, 1'b0, 8'hEF, 1'b0);
    chk("single_hold", Data_o, 8'h24);
    step(1'b0, 1'b0, 8'hEE, 1'b1);
    chk("drain1_valid", {7'd0, Valid_o}, 8'h00);
    chk("drain1_retain", Data_o, 8'h24);

    // Fill to FULL, third word refused
    step(1'b0, 1'b1, 8'h81, 1'b0);
    step(1'b0, 1'b1, 8'h09, 1'b0);
    chk("full_ready", {7'd0, Ready_o}, 8'h00);
    chk("full_data", Data_o, 8'h81);
    step(1'b0, 1'b1, 8'h63, 1'b0);
    chk("full_refuse_ready", {7'd0, Ready_o}, 8'h00);
    chk("full_refuse_data", Data_o, 8'h81);

    // Drain in order
    step(1'b0, 1'b1, 8'h63, 1'b1);
    chk("drain_w2", Data_o, 8'h09);
    chk("drain_ready", {7'd0, Ready_o}, 8'h01);
    step(1'b0, 1'b1, 8'h63, 1'b1);
    chk("drain_w3", Data_o, 8'h63);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("drain_empty", {7'd0, Valid_o}, 8'h00);

    // Streaming with 1-cycle latency
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, stream_w[i], 1'b1);
      chk("stream_data", Data_o, stream_w[i]);
      chk("stream_ready", {7'd0, Ready_o}, 8'h01);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // Reset while FULL discards both words
    step(1'b0, 1'b1, 8'hAA, 1'b0);
    step(1'b0, 1'b1, 8'hBB, 1'b0);
    chk("pre_rst_full", {7'd0, Ready_o}, 8'h00);
    step(1'b1, 1'b1, 8'hCC, 1'b1);
    chk("midrst_valid", {7'd0, Valid_o}, 8'h00);
    chk("midrst_ready", {7'd0, Ready_o}, 8'h01);
    chk("midrst_data", Data_o, 8'h00);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("post_rst_valid", {7'd0, Valid_o}, 8'h00);

    // Mixed valid/backpressure patterns, checked by the model
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    end

    @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
